// File: rtl/lif_pkg.sv
`default_nettype none
// ---- lif_pkg : shared FSM encoding and arithmetic helpers for lif_neuron_array -- rev 1.0 ----
package lif_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t CAPTURE = 2'd1;
  localparam state_t UPDATE  = 2'd2;
  localparam state_t FINISH  = 2'd3;

  // Unsigned add clamped to 2^w-1; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ---- lif_neuron_array_if : write / step / readback bus of the neuron array -- rev 1.0 ----
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 8,
  parameter int W         = 8
);
  localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                 cur_we;
  logic [AW-1:0]        cur_addr;
  logic [W-1:0]         cur_data;
  logic                 wr_err;
  logic [W-1:0]         threshold;
  logic                 step_valid;
  logic                 step_ready;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spike_vec;
  logic [AW-1:0]        rd_addr;
  logic [W-1:0]         rd_state;

  modport master (
    output cur_we, cur_addr, cur_data, threshold, step_valid, rd_addr,
    input  wr_err, step_ready, busy, done, spike_vec, rd_state
  );

  modport slave (
    input  cur_we, cur_addr, cur_data, threshold, step_valid, rd_addr,
    output wr_err, step_ready, busy, done, spike_vec, rd_state
  );
endinterface
`default_nettype wire

// File: rtl/lif_update_core.sv
`default_nettype none
// ---- lif_update_core : combinational leak/integrate/fire step for one neuron -- rev 1.0 ----
module lif_update_core
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  mem,
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  threshold,
  input  logic [RW-1:0] refr,
  output logic [W-1:0]  mem_n,
  output logic [RW-1:0] refr_n,
  output logic          spike
);

  logic [W-1:0] leaked;
  logic [31:0]  sum;

  assign leaked = mem - (mem >> LEAK_SHIFT);
  assign sum    = sat_add(32'(leaked), 32'(cur), unsigned'(W));

  always_comb begin
    spike  = 1'b0;
    mem_n  = mem;
    refr_n = refr;
    if (refr != '0) begin
      refr_n = refr - RW'(1);
      mem_n  = '0;
    end else if (sum >= 32'(threshold)) begin
      spike  = 1'b1;
      mem_n  = '0;
      refr_n = RW'(REFRACT);
    end else begin
      mem_n  = sum[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ---- lif_neuron_array : time-multiplexed sparse-scan LIF neuron array -- rev 1.0 ----
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 8,
  parameter int W             = 8,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRACT       = 2,
  parameter int CLEAR_ON_STEP = 0
) (
  input logic clk,
  input logic rst_n,
  lif_neuron_array_if.slave bus
);

  localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  state_t               state;
  logic [N_NEURONS-1:0] mask;
  logic [N_NEURONS-1:0] acc;
  logic [N_NEURONS-1:0] capture_mask;
  logic [N_NEURONS-1:0] spike_vec;
  logic [W-1:0]         thr;
  logic [W-1:0]         rd_state;
  logic                 wr_err;
  logic                 addr_ok;

  logic [W-1:0]  mem  [N_NEURONS];
  logic [W-1:0]  cur  [N_NEURONS];
  logic [RW-1:0] refr [N_NEURONS];

  logic [3:0]    idx;
  logic [W-1:0]  sel_mem;
  logic [W-1:0]  sel_cur;
  logic [RW-1:0] sel_refr;
  logic [W-1:0]  rd_mux;
  logic [W-1:0]  mem_n;
  logic [RW-1:0] refr_n;
  logic          spike;

  assign idx     = lowest_set(16'(mask));
  assign addr_ok = 32'(bus.cur_addr) < 32'(N_NEURONS);

  always_comb begin
    sel_mem      = '0;
    sel_cur      = '0;
    sel_refr     = '0;
    rd_mux       = '0;
    capture_mask = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      capture_mask[i] = (cur[i] != '0) | (mem[i] != '0) | (refr[i] != '0);
      if (idx == 4'(i)) begin
        sel_mem  = mem[i];
        sel_cur  = cur[i];
        sel_refr = refr[i];
      end
      if (bus.rd_addr == AW'(i)) rd_mux = mem[i];
    end
  end

  lif_update_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .RW         (RW)
  ) u_core (
    .mem       (sel_mem),
    .cur       (sel_cur),
    .threshold (thr),
    .refr      (sel_refr),
    .mem_n     (mem_n),
    .refr_n    (refr_n),
    .spike     (spike)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask      <= '0;
      acc       <= '0;
      thr       <= '0;
      spike_vec <= '0;
      rd_state  <= '0;
      wr_err    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i]  <= '0;
        cur[i]  <= '0;
        refr[i] <= '0;
      end
    end else begin
      rd_state <= rd_mux;
      wr_err   <= 1'b0;
      // Writes land only while idle, which includes the step accept cycle.
      if (bus.cur_we) begin
        if (state == IDLE && addr_ok) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.cur_addr == AW'(i)) cur[i] <= bus.cur_data;
          end
        end else begin
          wr_err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.step_valid) state <= CAPTURE;
        end
        CAPTURE: begin
          thr   <= bus.threshold;
          mask  <= capture_mask;
          acc   <= '0;
          state <= UPDATE;
        end
        UPDATE: begin
          if (mask == '0) begin
            state <= FINISH;
          end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
              if (idx == 4'(i)) begin
                mem[i]  <= mem_n;
                refr[i] <= refr_n;
                acc[i]  <= spike;
                mask[i] <= 1'b0;
                if (CLEAR_ON_STEP != 0) cur[i] <= '0;
              end
            end
          end
        end
        default: begin
          spike_vec <= acc;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.step_ready = (state == IDLE);
  assign bus.done       = (state == FINISH);
  assign bus.wr_err     = wr_err;
  assign bus.spike_vec  = spike_vec;
  assign bus.rd_state   = rd_state;

endmodule
`default_nettype wire
